// File: rtl/pool_pkg.sv
// Shared types for the pooling-window feeder and its bank storage.
package pool_pkg;

    // Compute-side sequencing of the external pool unit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } pool_feed_state_t;

endpackage

// File: rtl/pool_window_bank.sv
// One pooling-window buffer: size-entry register array plus its full flag.
// Contents are deliberately not reset; only the full flag defines validity.
module pool_window_bank
    import pool_pkg::*;
#(
    parameter int DW    = 20,
    parameter int size  = 4,
    parameter int width = $clog2(size)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [width-1:0]         wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic                     set_full,
    input  logic                     clr_full,
    output logic [size-1:0][DW-1:0]  words,
    output logic                     full
);

    logic [size-1:0][DW-1:0] words_r;
    logic                    full_r;

    // Window storage: written one element per accepted word, never while full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words_r[wr_idx] <= wr_data;
        end
    end

    // Full flag: set when the last element lands, cleared when the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else if (set_full) begin
            full_r <= 1'b1;
        end else if (clr_full) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign words = words_r;
    assign full  = full_r;

endmodule

// File: rtl/pool_window_feeder.sv
// Ping-pong window collector and sequencer for a reset-less min-pooling unit.
// Fill side loads one bank while the compute side runs the pool unit on the
// other; the pooled result leaves on a valid/ready stream.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int size  = 4,
    parameter int width = $clog2(size)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IL+FL-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [size-1:0][IL+FL-1:0]  pool_im,
    output logic                        pool_en,
    output logic                        pool_input_ready,
    input  logic [IL+FL-1:0]            pool_om,
    input  logic                        pool_done,
    output logic [IL+FL-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int DW = IL + FL;

    pool_feed_state_t        state_r;
    pool_feed_state_t        state_nxt_s;
    logic                    fill_bank_r;
    logic                    fill_bank_nxt_s;
    logic                    cmp_bank_r;
    logic [width-1:0]        fill_cnt_r;
    logic [1:0]              full_s;
    logic [1:0]              full_nxt_s;
    logic [1:0]              set_full_s;
    logic [1:0]              clr_full_s;
    logic [1:0]              wr_en_s;
    logic                    accept_s;
    logic                    wrap_s;
    logic                    drain_fire_s;
    logic [size-1:0][DW-1:0] bank_words_s [2];

    // Fill-side handshake decode and per-bank set/clear/write strobes.
    always_comb begin
        accept_s     = in_valid && in_ready;
        wrap_s       = accept_s && (fill_cnt_r == width'(size - 1));
        drain_fire_s = (state_r == DRAIN) && (!out_valid || out_ready);
        wr_en_s      = 2'b00;
        set_full_s   = 2'b00;
        clr_full_s   = 2'b00;
        if (fill_bank_r) begin
            wr_en_s[1]    = accept_s;
            set_full_s[1] = wrap_s;
        end else begin
            wr_en_s[0]    = accept_s;
            set_full_s[0] = wrap_s;
        end
        if (cmp_bank_r) begin
            clr_full_s[1] = drain_fire_s;
        end else begin
            clr_full_s[0] = drain_fire_s;
        end
        full_nxt_s      = (full_s | set_full_s) & ~clr_full_s;
        fill_bank_nxt_s = wrap_s ? ~fill_bank_r : fill_bank_r;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pool_window_bank #(
            .DW    (DW),
            .size  (size),
            .width (width)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en_s[g]),
            .wr_idx   (fill_cnt_r),
            .wr_data  (in_data),
            .set_full (set_full_s[g]),
            .clr_full (clr_full_s[g]),
            .words    (bank_words_s[g]),
            .full     (full_s[g])
        );
    end

    // Fill pointer, element counter and registered in_ready (no out_ready path).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank_r <= 1'b0;
            fill_cnt_r  <= '0;
            in_ready    <= 1'b0;
        end else begin
            fill_bank_r <= fill_bank_nxt_s;
            if (wrap_s) begin
                fill_cnt_r <= '0;
            end else if (accept_s) begin
                fill_cnt_r <= fill_cnt_r + width'(1);
            end else begin
                fill_cnt_r <= fill_cnt_r;
            end
            in_ready <= fill_bank_nxt_s ? !full_nxt_s[1] : !full_nxt_s[0];
        end
    end

    // Window presented to the pool unit; the selected bank is frozen while full.
    always_comb begin
        if (cmp_bank_r) begin
            pool_im = bank_words_s[1];
        end else begin
            pool_im = bank_words_s[0];
        end
    end

    // Compute FSM next state; pool_done only matters while running.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmp_bank_r ? full_s[1] : full_s[0]) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (pool_done) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, pool-unit controls registered from the next state, compute bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            pool_en          <= 1'b0;
            pool_input_ready <= 1'b0;
            cmp_bank_r       <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            pool_en          <= (state_nxt_s == LOAD) || (state_nxt_s == RUN);
            pool_input_ready <= (state_nxt_s == LOAD);
            cmp_bank_r       <= drain_fire_s ? ~cmp_bank_r : cmp_bank_r;
        end
    end

    // Output stream register: reload from the frozen pool result, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (drain_fire_s) begin
            out_data  <= pool_om;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_data  <= out_data;
            out_valid <= 1'b0;
        end else begin
            out_data  <= out_data;
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed plus randomized bench for pool_window_feeder paired with a
// behavioural min-pooling unit; results are checked against window minima.
module tb_pool_window_feeder;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int SIZE = 4;
    localparam int DW   = IL + FL;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [DW-1:0]           in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [SIZE-1:0][DW-1:0] pool_im;
    logic                    pool_en;
    logic                    pool_input_ready;
    logic [DW-1:0]           pool_om;
    logic                    pool_done;
    logic [DW-1:0]           out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool_window_feeder #(.IL(IL), .FL(FL), .size(SIZE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pool_im          (pool_im),
        .pool_en          (pool_en),
        .pool_input_ready (pool_input_ready),
        .pool_om          (pool_om),
        .pool_done        (pool_done),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    // Behavioural pool unit: latches on load, scans one element per run cycle,
    // raises done on the size-th run cycle; no reset.
    int            m_cnt = 0;
    logic [DW-1:0] m_min = '0;
    always @(posedge clk) begin
        if (pool_en && pool_input_ready) begin
            m_cnt <= 0;
            m_min <= pool_im[0];
        end else if (pool_en && m_cnt < SIZE - 1) begin
            m_cnt <= m_cnt + 1;
            if (pool_im[m_cnt + 1] < m_min) m_min <= pool_im[m_cnt + 1];
        end
    end
    assign pool_om   = m_min;
    assign pool_done = pool_en && !pool_input_ready && (m_cnt == SIZE - 1);

    // Reference model and observers.
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            run_q[$];
    int            run_cnt = 0;

    function automatic logic [DW-1:0] qmin(input logic [DW-1:0] q[$]);
        logic [DW-1:0] m;
        m = q[0];
        foreach (q[i]) if (q[i] < m) m = q[i];
        return m;
    endfunction

    // Group accepted words into windows, record outputs and run lengths.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                if (acc_q.size() == SIZE) begin
                    exp_q.push_back(qmin(acc_q));
                    acc_q.delete();
                end
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (pool_en && !pool_input_ready) begin
                run_cnt <= run_cnt + 1;
            end else if (run_cnt != 0) begin
                run_q.push_back(run_cnt);
                run_cnt <= 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 500) begin
            step();
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 2000) begin
            step();
            t++;
        end
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    endtask

    task automatic cmp_results(input string tag);
        chk({tag, "_nres"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_res"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_q();
        acc_q.delete();
        exp_q.delete();
        got_q.delete();
        run_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pir;
        int t;
        int sent;
        int guard;
        int stable_err;
        bit held;
        bit acc_now;
        logic [DW-1:0] hold_val;
        logic [DW-1:0] bw [12];

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_pool_en", 32'(pool_en), 32'd0);
        chk("rst_pool_ir", 32'(pool_input_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        clear_q();

        // Single window with latency and load-pulse width
        send(20'h00050);
        send(20'h00010);
        send(20'h00030);
        send(20'h00020);
        n = 1;
        pir = 0;
        while (!out_valid && n < 40) begin
            pir += int'(pool_input_ready);
            step();
            n++;
        end
        chk("single_latency", 32'(n), 32'd8);
        chk("single_load_pulse", 32'(pir), 32'd1);
        chk("single_data", 32'(out_data), 32'h00010);
        wait_results(1, "single");
        cmp_results("single");
        chk("single_run_len", 32'(run_q.size() > 0 ? run_q[0] : 0), 32'(SIZE));

        // Ping-pong: three windows back to back
        clear_q();
        for (int i = 0; i < 8; i++) send(DW'($urandom));
        chk("pp_in_ready_drop", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk("pp_recover_cycles", 32'(t), 32'd3);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(DW'($urandom));
        wait_results(3, "pp");
        cmp_results("pp");

        // Backpressure across two windows
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(DW'($urandom));
        stable_err = 0;
        held = 1'b0;
        hold_val = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) begin
                if (!held) begin
                    held = 1'b1;
                    hold_val = out_data;
                end else if (out_data !== hold_val) begin
                    stable_err++;
                end
            end
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'(exp_q.size() > 0 ? exp_q[0] : '0));
        chk("bp_stable", 32'(stable_err), 32'd0);
        chk("bp_pool_en", 32'(pool_en), 32'd0);
        chk("bp_no_handshake", 32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
        wait_results(2, "bp");
        cmp_results("bp");

        // Boundaries: min first, min last, all equal
        clear_q();
        bw = '{20'h00001, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF,
               20'h00050, 20'h00040, 20'h00030, 20'h00005,
               20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
        for (int i = 0; i < 12; i++) send(bw[i]);
        wait_results(3, "bnd");
        cmp_results("bnd");
        chk("bnd_first", 32'(got_q.size() > 0 ? got_q[0] : '0), 32'h00001);
        chk("bnd_last", 32'(got_q.size() > 1 ? got_q[1] : '0), 32'h00005);
        chk("bnd_equal", 32'(got_q.size() > 2 ? got_q[2] : '0), 32'h7FFFF);

        // Reset in the middle of RUN with a partial second window
        clear_q();
        for (int i = 0; i < 6; i++) send(DW'($urandom));
        t = 0;
        while (!(pool_en && !pool_input_ready) && t < 50) begin
            step();
            t++;
        end
        chk("rr_run_seen", 32'(pool_en && !pool_input_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_pool_en", 32'(pool_en), 32'd0);
        chk("rr_pool_ir", 32'(pool_input_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rr_in_ready", 32'(in_ready), 32'd1);
        chk("rr_no_output", 32'(out_valid), 32'd0);
        clear_q();
        send(20'h00300);
        send(20'h000A0);
        send(20'h000B0);
        send(20'h00200);
        wait_results(1, "rr");
        cmp_results("rr");
        chk("rr_value", 32'(got_q.size() > 0 ? got_q[0] : '0), 32'h000A0);

        // Random input bubbles and output stalls over 16 windows
        step();
        clear_q();
        sent = 0;
        guard = 0;
        while (sent < 16 * SIZE && guard < 5000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_now   = in_valid && in_ready;
            step();
            if (acc_now) sent++;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bub_sent", 32'(sent), 32'(16 * SIZE));
        wait_results(16, "bub");
        repeat (3) step();
        cmp_results("bub");
        chk("bub_runs", 32'(run_q.size()), 32'd16);
        foreach (run_q[i]) chk("bub_run_len", 32'(run_q[i]), 32'(SIZE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
